// File: rtl/branch_comparator_if.sv
// Operand, control and flag bundle for the RV32 branch comparator.
// Optional counter signals exist only when BRANCH_COMP_STATS_EN is defined.
interface branch_comparator_if #(
    parameter int n = 32
);
    logic [n-1:0] data1;
    logic [n-1:0] data2;
    logic         BrUn;
    logic [2:0]   funct3;
    logic         br_valid;
    logic         BrEq;
    logic         BrLT;
    logic         br_taken;
    logic         br_taken_q;
    logic         br_valid_q;
`ifdef BRANCH_COMP_STATS_EN
    logic [31:0]  taken_cnt;
    logic [31:0]  branch_cnt;

    modport master (
        output data1, data2, BrUn, funct3, br_valid,
        input  BrEq, BrLT, br_taken, br_taken_q, br_valid_q, taken_cnt, branch_cnt
    );
    modport slave (
        input  data1, data2, BrUn, funct3, br_valid,
        output BrEq, BrLT, br_taken, br_taken_q, br_valid_q, taken_cnt, branch_cnt
    );
`else
    modport master (
        output data1, data2, BrUn, funct3, br_valid,
        input  BrEq, BrLT, br_taken, br_taken_q, br_valid_q
    );
    modport slave (
        input  data1, data2, BrUn, funct3, br_valid,
        output BrEq, BrLT, br_taken, br_taken_q, br_valid_q
    );
`endif
endinterface

// File: rtl/branch_comparator.sv
// RV32 execute-stage branch comparator: combinational eq/lt flags, funct3 decision,
// one-cycle registered copy. Define BRANCH_COMP_STATS_EN for branch/taken counters.
module branch_comparator #(
    parameter int n = 32
) (
    input logic               clk,
    input logic               rst,
    branch_comparator_if.slave bus
);
    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } branchOp_e;

    logic brEq;
    logic brLT;
    logic brTaken;

    always_comb begin
        brEq = (bus.data1 == bus.data2);
        // Signed order: differing sign bits decide alone; equal signs fall back to magnitude.
        if (bus.BrUn)
            brLT = (bus.data1 < bus.data2);
        else if (bus.data1[n-1] != bus.data2[n-1])
            brLT = bus.data1[n-1];
        else
            brLT = (bus.data1[n-2:0] < bus.data2[n-2:0]);
    end

    always_comb begin
        brTaken = 1'b0;
        if (bus.br_valid) begin
            case (branchOp_e'(bus.funct3))
                BEQ:         brTaken = brEq;
                BNE:         brTaken = !brEq;
                BLT, BLTU:   brTaken = brLT;
                BGE, BGEU:   brTaken = !brLT;
                default:     brTaken = 1'b0;
            endcase
        end
    end

    assign bus.BrEq     = brEq;
    assign bus.BrLT     = brLT;
    assign bus.br_taken = brTaken;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.br_taken_q <= 1'b0;
            bus.br_valid_q <= 1'b0;
        end else begin
            bus.br_taken_q <= brTaken;
            bus.br_valid_q <= bus.br_valid;
        end
    end

`ifdef BRANCH_COMP_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.branch_cnt <= '0;
            bus.taken_cnt  <= '0;
        end else if (bus.br_valid) begin
            bus.branch_cnt <= bus.branch_cnt + 32'd1;
            if (brTaken)
                bus.taken_cnt <= bus.taken_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_comparator.sv
// Scoreboard bench for branch_comparator: directed vectors push expected flags,
// a negedge monitor pops and compares.
module tb_branch_comparator;
    logic clk = 1'b0;
    logic rst;

    branch_comparator_if #(.n(32)) bus ();

    branch_comparator #(.n(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        eq;
        logic        lt;
        logic        taken;
        logic        tq;
        logic        vq;
        logic [31:0] bc;
        logic [31:0] tc;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Bench-side register model, advanced once per rising edge by the stimulus
    logic        lastRst   = 1'b1;
    logic        lastValid = 1'b0;
    logic        lastTaken = 1'b0;
    logic        expTq;
    logic        expVq;
    logic [31:0] expBc = '0;
    logic [31:0] expTc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run(input string name, input logic r, input logic [31:0] d1,
                       input logic [31:0] d2, input logic un, input logic [2:0] f3,
                       input logic v, input logic eEq, input logic eLt, input logic eTaken);
        exp_t e;
        @(posedge clk);
        expTq = lastRst ? 1'b0 : lastTaken;
        expVq = lastRst ? 1'b0 : lastValid;
        if (lastRst) begin
            expBc = '0;
            expTc = '0;
        end else if (lastValid) begin
            expBc = expBc + 32'd1;
            if (lastTaken) expTc = expTc + 32'd1;
        end
        #1;
        rst          = r;
        bus.data1    = d1;
        bus.data2    = d2;
        bus.BrUn     = un;
        bus.funct3   = f3;
        bus.br_valid = v;
        e.name = name; e.eq = eEq; e.lt = eLt; e.taken = eTaken;
        e.tq = expTq; e.vq = expVq; e.bc = expBc; e.tc = expTc;
        sbq.push_back(e);
        lastRst = r; lastValid = v; lastTaken = eTaken;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check({e.name, ".BrEq"},       {31'd0, bus.BrEq},       {31'd0, e.eq});
                check({e.name, ".BrLT"},       {31'd0, bus.BrLT},       {31'd0, e.lt});
                check({e.name, ".br_taken"},   {31'd0, bus.br_taken},   {31'd0, e.taken});
                check({e.name, ".br_taken_q"}, {31'd0, bus.br_taken_q}, {31'd0, e.tq});
                check({e.name, ".br_valid_q"}, {31'd0, bus.br_valid_q}, {31'd0, e.vq});
`ifdef BRANCH_COMP_STATS_EN
                check({e.name, ".branch_cnt"}, bus.branch_cnt, e.bc);
                check({e.name, ".taken_cnt"},  bus.taken_cnt,  e.tc);
`endif
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        bus.data1 = '0; bus.data2 = '0; bus.BrUn = 1'b0;
        bus.funct3 = 3'b000; bus.br_valid = 1'b0;

        //   name         rst  data1         data2         BrUn funct3 valid  eq   lt   taken
        run("eqSigned",   1,   32'hA5A5A5A5, 32'hA5A5A5A5, 0,   3'b000, 0,   1,   0,   0);
        run("eqZeroUns",  1,   32'h00000000, 32'h00000000, 1,   3'b000, 0,   1,   0,   0);
        run("bltuLess",   0,   32'h00000001, 32'h00000010, 1,   3'b110, 1,   0,   1,   1);
        run("bgeuGreat",  0,   32'h00000020, 32'h00000010, 1,   3'b111, 1,   0,   0,   1);
        run("bltNegPos",  0,   32'hFFFFFFF0, 32'h00000010, 0,   3'b100, 1,   0,   1,   1);
        run("bltMaxPos",  0,   32'h7FFFFFFF, 32'h00000010, 0,   3'b100, 1,   0,   0,   0);
        run("bltuNegPos", 0,   32'hFFFFFFF0, 32'h00000010, 1,   3'b110, 1,   0,   0,   0);
        run("bgeMinMax",  0,   32'h80000000, 32'h7FFFFFFF, 0,   3'b101, 1,   0,   1,   0);
        run("bltMinMax",  0,   32'h80000000, 32'h7FFFFFFF, 0,   3'b100, 1,   0,   1,   1);
        run("rstHold1",   1,   32'h80000000, 32'h7FFFFFFF, 0,   3'b100, 1,   0,   1,   1);
        run("rstHold2",   1,   32'h80000000, 32'h7FFFFFFF, 0,   3'b100, 1,   0,   1,   1);
        run("postRst",    0,   32'h80000000, 32'h7FFFFFFF, 0,   3'b100, 1,   0,   1,   1);
        run("beqTaken",   0,   32'h12345678, 32'h12345678, 0,   3'b000, 1,   1,   0,   1);
        run("idleEq",     0,   32'h12345678, 32'h12345678, 0,   3'b000, 0,   1,   0,   0);
        run("bneEqual",   0,   32'h00000005, 32'h00000005, 0,   3'b001, 1,   1,   0,   0);
        run("illegal010", 0,   32'h00000005, 32'h00000005, 0,   3'b010, 1,   1,   0,   0);
        run("idleLess",   0,   32'h00000001, 32'h00000002, 0,   3'b100, 0,   0,   1,   0);
        run("bneDiffer",  0,   32'h00000005, 32'h00000006, 0,   3'b001, 1,   0,   1,   1);
        run("statsRst",   1,   32'h00000000, 32'h00000000, 0,   3'b000, 0,   1,   0,   0);
        run("afterStats", 0,   32'hFFFFFFFF, 32'h00000000, 1,   3'b111, 1,   0,   0,   1);
        run("tail",       0,   32'h00000000, 32'hFFFFFFFF, 0,   3'b011, 1,   0,   0,   0);

        @(negedge clk);
        #1;
        check("scoreboardDrained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/branch_comparator.md
Name: branch_comparator

Overview:
- RV32 branch comparator for the execute stage.
- Compares two register operands and produces equal and less-than flags combinationally, with signed or unsigned ordering selected by BrUn.
- Also decodes the branch funct3 into a taken decision.
- Also provides a one-cycle registered copy of the decision for the PC-select/flush logic.

Parameters:
- n, 32, operand width in bits; must be 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data1  input  n  operand A (rs1 value).
- data2  input  n  operand B (rs2 value).
- BrUn  input  1  1 = unsigned compare, 0 = two's-complement signed compare.
- funct3  input  3  branch type: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
- br_valid  input  1  current instruction is a conditional branch.
- BrEq  output  1  combinational: data1 == data2.
- BrLT  output  1  combinational: data1 < data2 under the BrUn ordering.
- br_taken  output  1  combinational branch decision.
- br_taken_q  output  1  br_taken registered.
- br_valid_q  output  1  br_valid registered.

Behaviour:
- BrEq and BrLT:
  - Purely combinational from data1, data2 and BrUn.
  - Independent of clk and rst; valid within the same delta/cycle as the inputs, including while rst is asserted and with no clock running.
- BrEq = 1 iff all n bits are equal, regardless of BrUn.
- BrLT when BrUn = 1: unsigned magnitude compare.
- BrLT when BrUn = 0: signed compare. If the MSBs differ, BrLT = data1[n-1]; otherwise use the unsigned compare of the remaining bits.
- When the operands are equal, BrLT = 0 in both modes.
- Examples:
  - 0xFFFFFFF0 vs 0x00000010: signed gives BrLT = 1; unsigned gives BrLT = 0.
  - 0x80000000 vs 0x7FFFFFFF: signed gives BrLT = 1.
- br_taken is 0 when br_valid = 0. Otherwise it is decoded from funct3:
  - BEQ: BrEq
  - BNE: !BrEq
  - BLT and BLTU: BrLT
  - BGE and BGEU: !BrLT
  - 010 and 011: 0 (illegal, not taken)
- br_taken uses the externally supplied BrUn. The caller drives BrUn = funct3[1] for branches; the block does not override it.
- Registered outputs:
  - On each rising clk: br_taken_q <= br_taken and br_valid_q <= br_valid.
  - Latency is 1 cycle.
  - No handshake or backpressure; new operands are accepted every cycle.
- Reset: while rst = 1 at a rising edge, br_taken_q = 0 and br_valid_q = 0. Combinational outputs continue to track their inputs during reset.
- Reset takes priority over the register update on the same edge. The first post-reset edge captures normally.
- No X-propagation masking is required; X or Z inputs give X outputs.

Optional Feature:
- Macro BRANCH_COMP_STATS_EN.
- When defined, add two outputs: taken_cnt (32-bit) and branch_cnt (32-bit).
  - branch_cnt increments on each rising edge where br_valid = 1.
  - taken_cnt increments on each rising edge where br_valid = 1 and br_taken = 1.
  - Both counters wrap modulo 2^32 and clear to 0 on rst.
- When not defined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- data1 = data2 = 0xA5A5A5A5, BrUn = 0 -> BrEq = 1, BrLT = 0. Then BrUn = 1 with 0x00000000 for both operands -> BrEq = 1, BrLT = 0.
- BrUn = 1: 0x00000001 vs 0x00000010 -> BrEq = 0, BrLT = 1. Then 0x00000020 vs 0x00000010 -> BrEq = 0, BrLT = 0.
- BrUn = 0:
  - 0xFFFFFFF0 vs 0x00000010 -> BrLT = 1.
  - 0x7FFFFFFF vs 0x00000010 -> BrLT = 0.
  - The same 0xFFFFFFF0 vs 0x00000010 with BrUn = 1 -> BrLT = 0.
- br_valid = 1, funct3 = 101, BrUn = 0, data1 = 0x80000000, data2 = 0x7FFFFFFF -> br_taken = 0. With funct3 = 100 -> br_taken = 1, and br_taken_q = 1 one edge later.
- Hold rst = 1 for 2 edges while br_valid = 1 and the branch is taken -> br_taken_q = 0 and br_valid_q = 0, while BrEq and BrLT still track the operands. After deassertion, the first edge loads br_taken_q = 1.
- With BRANCH_COMP_STATS_EN: 5 valid branches, 3 taken, plus 2 cycles with br_valid = 0 -> branch_cnt = 5, taken_cnt = 3. Then rst -> both counters read 0.
